fsm_1_mealy: RTL and testbench



---
 rtl/fsm_1_mealy.sv | 45 ++++
 tb/tb_fsm_1_mealy.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fsm_1_mealy.sv
// Two-state Mealy toggle FSM with an IDLE start state.
// While din is high it alternates S0/S1, and dout is high only in S1 with din high.
module fsm_1_mealy (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       dout,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    S0   = 2'b01,
    S1   = 2'b10
  } state_t;

  state_t state_reg;
  state_t state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // The unused 2'b11 code falls into the default branch and recovers to IDLE.
  always_comb begin
    state_next = IDLE;
    dout       = 1'b0;
    case (state_reg)
      IDLE: state_next = S0;
      S0:   state_next = din ? S1 : S0;
      S1: begin
        state_next = din ? S0 : S1;
        dout       = din & ~rst;
      end
      default: state_next = IDLE;
    endcase
  end

  assign state = state_reg;

endmodule

// File: tb/tb_fsm_1_mealy.sv
// Directed bench for fsm_1_mealy. It covers reset, startup, the square wave, the hold states,
// the combinational dout path and an asynchronous mid-run reset.
module tb_fsm_1_mealy;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       dout;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_st;

  fsm_1_mealy dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] est, input logic edout);
    total++;
    assert (state === est) else begin
      bad++;
      $error("FAIL %s state: got %b want %b", tag, state, est);
    end
    total++;
    assert (dout === edout) else begin
      bad++;
      $error("FAIL %s dout: got %b want %b", tag, dout, edout);
    end
    $display("check %s: state=%b dout=%b (want %b/%b)", tag, state, dout, est, edout);
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for two edges with din high.
    rst = 1'b1;
    din = 1'b1;
    #1;
    chk("reset_async", 2'b00, 1'b0);
    for (int i = 0; i < 2; i++) begin
      edge_step();
      chk("reset_hold", 2'b00, 1'b0);
    end

    // Startup: IDLE -> S0 -> S1.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release", 2'b00, 1'b0);
    edge_step();
    chk("start_s0", 2'b01, 1'b0);
    edge_step();
    chk("start_s1", 2'b10, 1'b1);

    // Square wave over 20 edges.
    exp_st = 2'b10;
    for (int i = 0; i < 20; i++) begin
      edge_step();
      exp_st = (exp_st == 2'b10) ? 2'b01 : 2'b10;
      chk("square", exp_st, exp_st == 2'b10);
    end

    // Hold in S1 with din low.
    @(negedge clk);
    din = 1'b0;
    #1;
    chk("s1_din0_now", 2'b10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      edge_step();
      chk("hold_s1", 2'b10, 1'b0);
    end
    @(negedge clk);
    din = 1'b1;
    #1;
    chk("s1_din1_now", 2'b10, 1'b1);
    edge_step();
    chk("to_s0", 2'b01, 1'b0);

    // Hold in S0 with din low.
    @(negedge clk);
    din = 1'b0;
    #1;
    chk("s0_din0_now", 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) begin
      edge_step();
      chk("hold_s0", 2'b01, 1'b0);
    end

    // Combinational Mealy path inside S1.
    @(negedge clk);
    din = 1'b1;
    edge_step();
    chk("to_s1", 2'b10, 1'b1);
    @(negedge clk);
    din = 1'b0;
    #1;
    chk("mealy_lo", 2'b10, 1'b0);
    din = 1'b1;
    #1;
    chk("mealy_hi", 2'b10, 1'b1);
    din = 1'b0;
    #1;
    chk("mealy_lo2", 2'b10, 1'b0);
    din = 1'b1;
    #1;
    chk("mealy_hi2", 2'b10, 1'b1);
    edge_step();
    chk("after_mealy", 2'b01, 1'b0);
    edge_step();
    chk("sq_resume", 2'b10, 1'b1);

    // Mid-run asynchronous reset, asserted between edges while in S1 with dout high.
    #2;
    rst = 1'b1;
    #1;
    chk("midrun_rst", 2'b00, 1'b0);
    edge_step();
    chk("midrun_hold", 2'b00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    edge_step();
    chk("restart_s0", 2'b01, 1'b0);
    edge_step();
    chk("restart_s1", 2'b10, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
